// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC sequencer: FSM states, register offsets
// (as decoded from PADDR[3:2]) and bit positions inside CTRL, DATA and STATUS.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CONV,
        ST_READ,
        ST_GAP
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CONT    = 1;
    localparam int CTRL_IRQEN   = 2;
    localparam int CTRL_SWSTART = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_TOUT    = 2;

    localparam int DATA_VALID   = 31;

endpackage

// File: rtl/adc_seq_regs.sv
// APB register file for the ADC sequencer: CTRL/PERIOD storage, the captured
// sample with its VALID flag, sticky OVERRUN/TOUT flags and the interrupt.
module adc_seq_regs
    import adc_seq_pkg::*;
#(
    parameter int ADC_WIDTH = 12,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [13:0]          PADDR,
    input  logic [31:0]          PWDATA,
    output logic [31:0]          PRDATA,
    input  logic                 busy,
    input  logic                 capture,
    input  logic [ADC_WIDTH-1:0] capture_data,
    input  logic                 tout_set,
    output logic                 en,
    output logic                 cont,
    output logic                 irqen,
    output logic [DIV_WIDTH-1:0] period,
    output logic                 swstart,
    output logic                 irq
);

    logic [1:0]           sel;
    logic                 wr;
    logic                 rd;
    logic                 data_rd;
    logic [ADC_WIDTH-1:0] result;
    logic                 valid;
    logic                 overrun;
    logic                 tout;
    logic                 unused_bits;

    assign sel     = PADDR[3:2];
    assign wr      = PSEL & PENABLE & PWRITE;
    assign rd      = PSEL & PENABLE & ~PWRITE;
    assign data_rd = rd && (sel == REG_DATA);

    // A software start also needs EN in the same write, so EN=1+SWSTART in
    // one access launches a conversion; it is dropped while a sequence runs.
    assign swstart = wr && (sel == REG_CTRL) && PWDATA[CTRL_SWSTART]
                     && PWDATA[CTRL_EN] && !busy;

    assign unused_bits = ^{PADDR[13:4], PADDR[1:0], PWDATA[31:DIV_WIDTH]};

    // Control and period registers
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            en     <= 1'b0;
            cont   <= 1'b0;
            irqen  <= 1'b0;
            period <= '0;
        end else if (wr) begin
            if (sel == REG_CTRL) begin
                en    <= PWDATA[CTRL_EN];
                cont  <= PWDATA[CTRL_CONT];
                irqen <= PWDATA[CTRL_IRQEN];
            end
            if (sel == REG_PERIOD) begin
                period <= PWDATA[DIV_WIDTH-1:0];
            end
        end
    end

    // Sample capture; a capture beats a concurrent read-clear of VALID, and a
    // read in the same cycle counts as consuming the old sample (no overrun)
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            result  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (capture) begin
                result <= capture_data;
                valid  <= 1'b1;
            end else if (data_rd) begin
                valid <= 1'b0;
            end
            if (capture && valid && !data_rd) begin
                overrun <= 1'b1;
            end else if (wr && (sel == REG_STATUS) && PWDATA[STAT_OVERRUN]) begin
                overrun <= 1'b0;
            end
        end
    end

    // Sticky timeout flag, set has priority over write-1-to-clear
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            tout <= 1'b0;
        end else if (tout_set) begin
            tout <= 1'b1;
        end else if (wr && (sel == REG_STATUS) && PWDATA[STAT_TOUT]) begin
            tout <= 1'b0;
        end
    end

    // Level interrupt, registered
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            irq <= 1'b0;
        end else begin
            irq <= irqen & (valid | tout);
        end
    end

    // Read mux, zero outside of read cycles
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (sel)
                REG_CTRL: begin
                    PRDATA[CTRL_EN]    = en;
                    PRDATA[CTRL_CONT]  = cont;
                    PRDATA[CTRL_IRQEN] = irqen;
                end
                REG_PERIOD: begin
                    PRDATA[DIV_WIDTH-1:0] = period;
                end
                REG_DATA: begin
                    PRDATA[ADC_WIDTH-1:0] = result;
                    PRDATA[DATA_VALID]    = valid;
                end
                default: begin
                    PRDATA[STAT_BUSY]    = busy;
                    PRDATA[STAT_OVERRUN] = overrun;
                    PRDATA[STAT_TOUT]    = tout;
                end
            endcase
        end
    end

endmodule

// File: rtl/adc_seq_ctrl.sv
// ADC conversion sequencer: launches the SAR ADC, waits for EOC with a
// timeout, strobes output-enable for one cycle and, in continuous mode,
// idles PERIOD cycles between conversions.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for SWSTART or EN+CONT
// ST_START | adc_start high for this single cycle, timeout counter loaded
// ST_CONV  | waiting for adc_eoc, timeout counter running down
// ST_READ  | adc_oe high, sample captured at the end of the cycle
// ST_GAP   | continuous mode idle gap, PERIOD cycles long
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int ADC_WIDTH = 12,
    parameter int DIV_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [13:0]          PADDR,
    input  logic [31:0]          PWDATA,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 adc_start,
    output logic                 adc_oe,
    input  logic                 adc_eoc,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic                 irq
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t               state;
    logic [TW-1:0]        tcnt;
    logic [DIV_WIDTH-1:0] gcnt;
    logic                 en;
    logic                 cont;
    logic                 irqen;
    logic [DIV_WIDTH-1:0] period;
    logic                 swstart;
    logic                 busy;
    logic                 capture;
    logic                 tout_set;

    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;
    assign busy     = (state != ST_IDLE);
    assign capture  = (state == ST_READ) && en;
    assign tout_set = (state == ST_CONV) && en && !adc_eoc && (tcnt == '0);

    adc_seq_regs #(
        .ADC_WIDTH (ADC_WIDTH),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_regs (
        .clk          (clk),
        .RSTn         (RSTn),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .busy         (busy),
        .capture      (capture),
        .capture_data (adc_data),
        .tout_set     (tout_set),
        .en           (en),
        .cont         (cont),
        .irqen        (irqen),
        .period       (period),
        .swstart      (swstart),
        .irq          (irq)
    );

    // Sequencer FSM with timeout and gap down-counters; a zero PERIOD skips
    // GAP entirely so the start-to-start interval has no hidden extra cycle
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ST_IDLE;
            adc_start <= 1'b0;
            adc_oe    <= 1'b0;
            tcnt      <= '0;
            gcnt      <= '0;
        end else begin
            adc_start <= 1'b0;
            adc_oe    <= 1'b0;
            if (state == ST_IDLE) begin
                if (swstart || (en && cont)) begin
                    state     <= ST_START;
                    adc_start <= 1'b1;
                end
            end else if (!en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_START: begin
                        state <= ST_CONV;
                        tcnt  <= TW'(TIMEOUT - 1);
                    end
                    ST_CONV: begin
                        if (adc_eoc) begin
                            state  <= ST_READ;
                            adc_oe <= 1'b1;
                        end else if (tcnt == '0) begin
                            if (!cont) begin
                                state <= ST_IDLE;
                            end else if (period == '0) begin
                                state     <= ST_START;
                                adc_start <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                                gcnt  <= period - DIV_WIDTH'(1);
                            end
                        end else begin
                            tcnt <= tcnt - TW'(1);
                        end
                    end
                    ST_READ: begin
                        if (!cont) begin
                            state <= ST_IDLE;
                        end else if (period == '0) begin
                            state     <= ST_START;
                            adc_start <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                            gcnt  <= period - DIV_WIDTH'(1);
                        end
                    end
                    ST_GAP: begin
                        if (!cont) begin
                            state <= ST_IDLE;
                        end else if (gcnt == '0) begin
                            state     <= ST_START;
                            adc_start <= 1'b1;
                        end else begin
                            gcnt <= gcnt - DIV_WIDTH'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: APB reads push their expected value into a
// scoreboard queue, a monitor pops and compares in the access phase. A
// simple ADC model answers each start pulse with EOC after 14 CONV cycles.
module tb_adc_seq_ctrl;

    logic        clk;
    logic        RSTn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [13:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        adc_start;
    logic        adc_oe;
    logic        adc_eoc;
    logic [11:0] adc_data;
    logic        irq;

    localparam logic [13:0] A_CTRL   = 14'h0;
    localparam logic [13:0] A_PERIOD = 14'h4;
    localparam logic [13:0] A_DATA   = 14'h8;
    localparam logic [13:0] A_STATUS = 14'hC;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_hi = 0;
    int   oe_hi    = 0;
    int   start_times[$];
    bit   model_on = 1'b1;
    int   conv_len = 14;

    adc_seq_ctrl dut (
        .clk       (clk),
        .RSTn      (RSTn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .adc_start (adc_start),
        .adc_oe    (adc_oe),
        .adc_eoc   (adc_eoc),
        .adc_data  (adc_data),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // pulse bookkeeping, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                start_hi = start_hi + 1;
                start_times.push_back(cyc);
            end
            if (adc_oe === 1'b1) oe_hi = oe_hi + 1;
        end
    end

    // ADC model: EOC high during the conv_len-th CONV cycle
    initial begin
        adc_eoc = 1'b0;
        forever begin
            @(negedge clk);
            if (adc_start === 1'b1 && model_on) begin
                repeat (conv_len) @(negedge clk);
                adc_eoc = 1'b1;
                @(negedge clk);
                adc_eoc = 1'b0;
            end
        end
    end

    // scoreboard monitor for APB reads
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (PSEL === 1'b1 && PENABLE === 1'b1 && PWRITE === 1'b0) begin
                n_checks = n_checks + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_read: read %08h, nothing expected", PRDATA);
                end else begin
                    e = exp_q.pop_front();
                    if (PRDATA !== e.val) begin
                        n_fail = n_fail + 1;
                        $display("FAIL %s: read %08h, expected %08h", e.name, PRDATA, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [13:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWDATA  = data;
        @(posedge clk);
        #1;
        PENABLE = 1'b1;
        @(posedge clk);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [13:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        PSEL    = 1'b1;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PADDR   = addr;
        @(posedge clk);
        #1;
        PENABLE = 1'b1;
        @(posedge clk);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic wait_start(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks = n_checks + 1;
        if (!found) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: adc_start not seen within 10 cycles", name);
        end
    endtask

    initial begin
        int s0;
        int o0;
        int n0;
        bit seen;

        RSTn     = 1'b0;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = '0;
        PWDATA   = '0;
        adc_data = 12'hABC;
        repeat (3) @(negedge clk);
        RSTn = 1'b1;

        // reset state
        check("rst_pready", {31'b0, PREADY}, 32'h1);
        check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
        check("rst_outputs", {29'b0, adc_start, adc_oe, irq}, 32'h0);
        apb_read(A_CTRL,   32'h0, "rst_ctrl");
        apb_read(A_PERIOD, 32'h0, "rst_period");
        apb_read(A_DATA,   32'h0, "rst_data");
        apb_read(A_STATUS, 32'h0, "rst_status");

        // single shot: start pulse in the cycle after the write edge
        s0 = start_hi;
        o0 = oe_hi;
        apb_write(A_CTRL, 32'h9);
        @(negedge clk);
        check("ss_start_hi", {31'b0, adc_start}, 32'h1);
        @(negedge clk);
        check("ss_start_lo", {31'b0, adc_start}, 32'h0);
        repeat (12) @(negedge clk);
        // this read lands in the READ cycle itself: old data, capture wins
        apb_read(A_DATA, 32'h0000_0000, "ss_data_during_read");
        apb_read(A_DATA, 32'h8000_0ABC, "ss_data_valid");
        apb_read(A_DATA, 32'h0000_0ABC, "ss_data_cleared");
        apb_read(A_STATUS, 32'h0, "ss_status");
        apb_read(A_CTRL, 32'h1, "ss_ctrl_swstart_reads0");
        check("ss_start_count", start_hi - s0, 32'd1);
        check("ss_oe_count", oe_hi - o0, 32'd1);

        // continuous mode: 1 + 14 + 1 + 10 = 26 cycles start to start
        apb_write(A_PERIOD, 32'd10);
        apb_read(A_PERIOD, 32'd10, "cont_period");
        n0 = start_times.size();
        s0 = start_hi;
        o0 = oe_hi;
        apb_write(A_CTRL, 32'h3);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (oe_hi - o0 >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        apb_write(A_CTRL, 32'h0);
        check("cont_two_captures", {31'b0, seen}, 32'h1);
        check("cont_start_count", start_hi - s0, 32'd2);
        if (start_times.size() >= n0 + 2)
            check("cont_interval", start_times[n0+1] - start_times[n0], 32'd26);
        else
            check("cont_interval_samples", start_times.size() - n0, 32'd2);
        apb_read(A_STATUS, 32'h2, "cont_overrun_set");
        apb_write(A_STATUS, 32'h2);
        apb_read(A_STATUS, 32'h0, "cont_overrun_cleared");
        apb_read(A_DATA, 32'h8000_0ABC, "cont_data");

        // timeout: no EOC, CONV lasts exactly 255 cycles
        model_on = 1'b0;
        apb_write(A_CTRL, 32'hD);
        wait_start("tout_start");
        repeat (253) @(negedge clk);
        apb_read(A_STATUS, 32'h1, "tout_last_conv_cycle");
        apb_read(A_STATUS, 32'h4, "tout_set_idle");
        check("tout_irq_high", {31'b0, irq}, 32'h1);
        apb_read(A_CTRL, 32'h5, "tout_ctrl");
        apb_write(A_STATUS, 32'h4);
        repeat (2) @(negedge clk);
        check("tout_irq_low", {31'b0, irq}, 32'h0);
        apb_read(A_STATUS, 32'h0, "tout_cleared");

        // EN cleared mid-conversion: abort, no capture
        model_on = 1'b1;
        adc_data = 12'h555;
        o0 = oe_hi;
        apb_write(A_CTRL, 32'h9);
        wait_start("enclr_start");
        repeat (3) @(negedge clk);
        apb_write(A_CTRL, 32'h0);
        apb_read(A_STATUS, 32'h0, "enclr_not_busy");
        repeat (30) @(negedge clk);
        check("enclr_no_oe", oe_hi - o0, 32'd0);
        apb_read(A_DATA, 32'h0000_0ABC, "enclr_data_unchanged");

        // asynchronous reset mid-conversion
        adc_data = 12'h123;
        apb_write(A_CTRL, 32'hD);
        wait_start("rst_conv1_start");
        repeat (30) @(negedge clk);
        check("rst_pre_irq", {31'b0, irq}, 32'h1);
        apb_write(A_CTRL, 32'hD);
        wait_start("rst_conv2_start");
        repeat (4) @(negedge clk);
        #2;
        RSTn = 1'b0;
        #1;
        check("rst_async_outputs", {29'b0, adc_start, adc_oe, irq}, 32'h0);
        @(negedge clk);
        RSTn = 1'b1;
        s0 = start_hi;
        o0 = oe_hi;
        repeat (40) @(negedge clk);
        check("rst_no_start", start_hi - s0, 32'd0);
        check("rst_no_oe", oe_hi - o0, 32'd0);
        apb_read(A_CTRL,   32'h0, "rst2_ctrl");
        apb_read(A_DATA,   32'h0, "rst2_data");
        apb_read(A_STATUS, 32'h0, "rst2_status");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

APB slave that sequences the external successive-approximation ADC (`uadc`) on behalf of the Cortex-M0. It issues start pulses, waits for end-of-conversion with a timeout, and strobes output-enable to capture the sample. Conversions run single-shot or periodically, and the result is exposed through four APB registers plus a level interrupt. It sits on one select of the APB slave mux, in place of the bare ADC register wrapper.

## Interface
- `ADC_WIDTH`, 12, ADC result width.
- `DIV_WIDTH`, 16, width of the period counter.
- `TIMEOUT`, 255, maximum number of clk cycles to wait for EOC.
- `clk` in 1: system clock.
- `RSTn` in 1: reset, asynchronous, active-low.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB enable.
- `PWRITE` in 1: APB write.
- `PADDR` in 14: APB address; only [3:2] are decoded.
- `PWDATA` in 32: APB write data.
- `PRDATA` out 32: APB read data.
- `PREADY` out 1: tied to 1.
- `PSLVERR` out 1: tied to 0.
- `adc_start` out 1: conversion start pulse.
- `adc_oe` out 1: ADC output enable.
- `adc_eoc` in 1: end of conversion, synchronous to clk, level.
- `adc_data` in ADC_WIDTH: conversion result, valid while adc_oe is high.
- `irq` out 1: level interrupt.

## Operation
- Register map:
  - 0x0 CTRL: [0] EN, [1] CONT, [2] IRQEN. Writing [3]=1 is SWSTART; it self-clears and reads as 0.
  - 0x4 PERIOD: [DIV_WIDTH-1:0], the number of idle cycles between conversions in continuous mode.
  - 0x8 DATA: [ADC_WIDTH-1:0] RESULT, [31] VALID. Any read clears VALID.
  - 0xC STATUS: [0] BUSY (read-only), [1] OVERRUN, [2] TOUT. OVERRUN and TOUT are write-1-to-clear.
- FSM states: IDLE, START, CONV, READ, GAP.
  - IDLE→START when EN=1 and (SWSTART written, or CONT=1).
  - START: adc_start=1 for exactly 1 cycle, then →CONV; the timeout counter is cleared.
  - CONV: on adc_eoc=1 →READ. If the count reaches TIMEOUT: set TOUT, then →GAP if CONT, else →IDLE.
  - READ: adc_oe=1 for 1 cycle. adc_data is captured into RESULT at the end of the cycle and VALID is set. If VALID was already 1, OVERRUN is set. Then →GAP if CONT, else →IDLE.
  - GAP: counts PERIOD cycles (PERIOD=0 means 0 extra cycles), then →START. Clearing CONT in GAP →IDLE.
- EN cleared in any state: return to IDLE on the next edge. adc_start and adc_oe drop immediately (registered low next cycle). No capture occurs.
- SWSTART while BUSY: ignored.
- BUSY = state≠IDLE.
- irq = IRQEN & (VALID | TOUT).

## Timing
- All outputs are registered, except PRDATA, PREADY and PSLVERR.
- Reset values: state IDLE, all registers 0, PRDATA 0, adc_start 0, adc_oe 0, irq 0.
- APB: zero wait states.
  - Writes commit on the clk edge where PSEL&PENABLE&PWRITE.
  - PRDATA is combinational from the registers when PSEL&!PWRITE, and 0 otherwise.
- Single shot: the SWSTART write edge, then adc_start high in cycle+1, CONV from cycle+2.
  - The RESULT/VALID update lands 1 cycle after the cycle in which adc_eoc is first sampled high, plus the READ cycle: visible 2 edges after EOC is sampled.
- Simultaneous DATA read and capture: the capture wins. VALID stays 1 and OVERRUN is not set.
- Simultaneous W1C and set of the same STATUS bit: the set wins.
- Continuous start-to-start interval = 1 (START) + conversion cycles + 1 (READ) + PERIOD.
- Reset mid-conversion: immediate return to IDLE, outputs low asynchronously.

## Structure
- Shared package `adc_seq_pkg`:
  - state enum;
  - register offset constants (CTRL, PERIOD, DATA, STATUS);
  - CTRL/STATUS bit-index constants.
- One sub-module, `adc_seq_regs`: APB decode, register file, W1C and read-clear logic.
- The FSM, timeout counter and GAP counter live in the top module.

## Test plan
- Reset, then read all four registers → all read 0; PREADY=1 and adc_start=adc_oe=irq=0.
- Write CTRL=0x9 (EN+SWSTART); drive adc_eoc after 14 cycles with adc_data=0xABC → one adc_start pulse, one adc_oe pulse, DATA reads 0x80000ABC; a second read returns 0x00000ABC.
- Write CTRL=0x3 with PERIOD=10 and a fixed 14-cycle conversion → start pulses exactly 26 cycles apart. Do not read DATA → OVERRUN=1 after the 2nd capture. Write STATUS=0x2 → OVERRUN=0.
- Single shot with adc_eoc held low → TOUT=1 after 255 CONV cycles, state IDLE. With IRQEN=1, irq=1; write STATUS=0x4 → irq=0.
- Clear EN during CONV → BUSY=0 next cycle, no adc_oe pulse, DATA unchanged.
- Assert RSTn low mid-CONV → outputs 0 immediately; after release, no activity until a new SWSTART.
